score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter N_LANES, default 32, number of dropper lanes feeding this block.
REQ-002 Parameter SCORE_W, default 16, score width.
REQ-003 frame_clk  input  1  sole clock, one edge per video frame.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 keycode  input  8  primary keyboard scan code.
REQ-006 hit  input  N_LANES  per-lane dropper score level; rises once when its arrow is struck in the window.
REQ-007 miss  input  N_LANES  per-lane level; rises when its arrow reaches Y_Max unscored.
REQ-008 score  output  SCORE_W  accumulated points.
REQ-009 combo  output  10  current consecutive-hit count.
REQ-010 max_combo  output  10  highest combo this round.
REQ-011 game_state  output  2  IDLE=0, PLAY=1, DONE=2.

Function
REQ-012 States: IDLE -> PLAY on keycode 8'h2C; PLAY -> DONE when every lane is resolved; DONE -> IDLE on keycode 8'h01; PLAY -> IDLE on keycode 8'h01 (abort); other codes hold state.
REQ-013 Edge detect: registered copies hit_q, miss_q; new_hit = hit & ~hit_q & ~resolved; new_miss = miss & ~miss_q & ~resolved & ~new_hit.
REQ-014 Same-lane simultaneous rising hit and miss: hit wins, lane resolved as hit.
REQ-015 resolved mask sets each lane on its first new_hit or new_miss; later edges on a resolved lane are ignored.
REQ-016 h = popcount(new_hit), m = popcount(new_miss), computed per frame in PLAY only.
REQ-017 Points per frame = h*10, plus h*5 if combo (pre-update) >= 10; score saturates at all-ones, never wraps.
REQ-018 Combo next: m>0 -> h; else combo+h; saturates at 1023.
REQ-019 max_combo next = max(max_combo, combo next).
REQ-020 All outputs registered; an input edge sampled at clock edge k appears on outputs after edge k (one-frame latency).
REQ-021 IDLE->PLAY transition clears score, combo, max_combo, resolved, in the same edge; hit/miss edges on that edge are ignored.
REQ-022 In IDLE and DONE, events are ignored and score/combo/max_combo hold.
REQ-023 PLAY->DONE evaluated on resolved-next: the frame resolving the last lane both scores it and enters DONE.
REQ-024 Abort (8'h01 in PLAY) returns to IDLE holding score values until next start.

Reset
REQ-025 Reset asserted asynchronously forces game_state=IDLE, score=0, combo=0, max_combo=0, resolved=0, hit_q=miss_q=0.
REQ-026 Reset mid-PLAY discards all in-progress accounting; deassertion resumes in IDLE at next frame_clk edge.
REQ-027 hit_q/miss_q keep sampling in every state so a level already high at start does not count as a new edge.

Structure
REQ-028 Shared package rhythm_pkg holds the game-state enum, keycodes KEY_START=8'h2C and KEY_RESET=8'h01, HIT_POINTS=10, COMBO_BONUS=5, COMBO_THRESH=10, COMBO_MAX=1023.
REQ-029 One sub-module lane_popcount (parameterised width, combinational count) instantiated twice for h and m.

Verification
REQ-030 Start, single rising hit[3] -> next frame score=10, combo=1, max_combo=1.
REQ-031 12 sequential single hits -> score=10*10+2*15=130, combo=12, max_combo=12.
REQ-032 Combo=5, hit[1] and miss[2] rise in same frame -> score+10, combo=1, max_combo stays 5.
REQ-033 hit[0] and miss[0] rise together -> counted as hit; later re-toggle of hit[0] -> no score change.
REQ-034 All N_LANES resolved -> game_state=DONE next frame; keycode 8'h01 -> IDLE; 8'h2C -> PLAY with all counters 0.
REQ-035 Reset asserted between clock edges during PLAY with score=200 -> outputs 0 and IDLE immediately, before next edge.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game scoring logic: game states,
// keyboard scan codes that drive the round flow, and scoring constants.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } game_state_e;

  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_RESET = 8'h01;

  localparam int unsigned HIT_POINTS   = 10;
  localparam int unsigned COMBO_BONUS  = 5;
  localparam int unsigned COMBO_THRESH = 10;
  localparam int unsigned COMBO_MAX    = 1023;

endpackage

// File: rtl/lane_popcount.sv
// Combinational population count of a lane mask.
module lane_popcount #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec_i,
  output logic [CNT_W-1:0] count_o
);

  // Sum the set bits of the lane mask.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Per-frame score, combo and round-state tracking for the rhythm game.
// Each lane resolves once per round, on its first rising hit or miss level.
module score_keeper
  import rhythm_pkg::*;
#(
  parameter int N_LANES = 32,
  parameter int SCORE_W = 16
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_LANES-1:0] hit,
  input  logic [N_LANES-1:0] miss,
  output logic [SCORE_W-1:0] score,
  output logic [9:0]         combo,
  output logic [9:0]         max_combo,
  output logic [1:0]         game_state
);

  localparam int CNT_W = $clog2(N_LANES + 1);
  // 16*h bounds the worst-case 15*h points earned in one frame.
  localparam int PTS_W = CNT_W + 4;
  localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;

  game_state_e        state_q, state_d;
  logic [N_LANES-1:0] hit_q, miss_q;
  logic [N_LANES-1:0] resolved_q, resolved_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [9:0]         combo_q, combo_d;
  logic [9:0]         max_combo_q, max_combo_d;

  logic [N_LANES-1:0] new_hit, new_miss;
  logic [CNT_W-1:0]   h, m;
  logic [PTS_W-1:0]   pts;
  logic [SUM_W-1:0]   score_sum;
  logic [10:0]        combo_sum;

  // A hit outranks a miss rising on the same lane in the same frame.
  assign new_hit  = hit & ~hit_q & ~resolved_q;
  assign new_miss = miss & ~miss_q & ~resolved_q & ~new_hit;

  lane_popcount #(.W(N_LANES), .CNT_W(CNT_W)) u_hit_count (
    .vec_i   (new_hit),
    .count_o (h)
  );

  lane_popcount #(.W(N_LANES), .CNT_W(CNT_W)) u_miss_count (
    .vec_i   (new_miss),
    .count_o (m)
  );

  // Next-state logic: round flow plus scoring of this frame's new events.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    resolved_d  = resolved_q;
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    pts         = '0;
    score_sum   = '0;
    combo_sum   = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Start wipes the previous round; edges on this frame are not scored.
        if (keycode == KEY_START) begin
          state_d     = ST_PLAY;
          resolved_d  = '0;
          score_d     = '0;
          combo_d     = '0;
          max_combo_d = '0;
        end
      end

      ST_PLAY: begin
        resolved_d = resolved_q | new_hit | new_miss;

        pts = PTS_W'(h) * PTS_W'(HIT_POINTS);
        if (combo_q >= 10'(COMBO_THRESH)) begin
          pts = pts + PTS_W'(h) * PTS_W'(COMBO_BONUS);
        end
        score_sum = SUM_W'(score_q) + SUM_W'(pts);
        score_d   = (score_sum[SUM_W-1:SCORE_W] != '0) ? '1
                                                       : score_sum[SCORE_W-1:0];

        // Any miss breaks the streak; hits from the same frame start the new one.
        combo_sum   = (m != '0) ? 11'(h) : (11'(combo_q) + 11'(h));
        combo_d     = (combo_sum > 11'(COMBO_MAX)) ? 10'(COMBO_MAX) : combo_sum[9:0];
        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;

        // Completion looks at the updated mask so the final lane ends the round.
        if (keycode == KEY_RESET) begin
          state_d = ST_IDLE;
        end else if (&resolved_d) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (keycode == KEY_RESET) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; the lane level history is sampled in every state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      hit_q       <= '0;
      miss_q      <= '0;
      resolved_q  <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of the others, independent of statement order.
      state_q     <= state_d;
      hit_q       <= hit;
      miss_q      <= miss;
      resolved_q  <= resolved_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed, table-driven bench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  localparam int N_LANES = 32;
  localparam int SCORE_W = 16;
  localparam int NV      = 18;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic               frame_clk;
  logic               Reset;
  logic [7:0]         keycode;
  logic [N_LANES-1:0] hit;
  logic [N_LANES-1:0] miss;
  logic [SCORE_W-1:0] score;
  logic [9:0]         combo;
  logic [9:0]         max_combo;
  logic [1:0]         game_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  key;
    logic [31:0] hit;
    logic [31:0] miss;
    logic [15:0] score;
    logic [9:0]  combo;
    logic [9:0]  maxc;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [NV];

  score_keeper #(.N_LANES(N_LANES), .SCORE_W(SCORE_W)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .game_state (game_state)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] s, input logic [9:0] c,
                           input logic [9:0] mc, input logic [1:0] st);
    check({tag, "_score"}, 32'(score), 32'(s));
    check({tag, "_combo"}, 32'(combo), 32'(c));
    check({tag, "_max"},   32'(max_combo), 32'(mc));
    check({tag, "_state"}, 32'(game_state), 32'(st));
  endtask

  // One frame: let the edge happen, then sample just after it.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    keycode = 8'h00;
    hit     = '0;
    miss    = '0;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  initial begin
    // Round 1: twelve single hits (bonus from the 11th on), a miss, abort,
    // an ignored event in IDLE, then a restart whose edge events are ignored.
    vecs[0]  = '{8'h2C, 32'h0000_0000, 32'h0000_0000,   0,  0,  0, S_PLAY};
    vecs[1]  = '{8'h00, 32'h0000_0008, 32'h0000_0000,  10,  1,  1, S_PLAY};
    vecs[2]  = '{8'h00, 32'h0000_0018, 32'h0000_0000,  20,  2,  2, S_PLAY};
    vecs[3]  = '{8'h00, 32'h0000_0038, 32'h0000_0000,  30,  3,  3, S_PLAY};
    vecs[4]  = '{8'h00, 32'h0000_0078, 32'h0000_0000,  40,  4,  4, S_PLAY};
    vecs[5]  = '{8'h00, 32'h0000_00F8, 32'h0000_0000,  50,  5,  5, S_PLAY};
    vecs[6]  = '{8'h00, 32'h0000_01F8, 32'h0000_0000,  60,  6,  6, S_PLAY};
    vecs[7]  = '{8'h00, 32'h0000_03F8, 32'h0000_0000,  70,  7,  7, S_PLAY};
    vecs[8]  = '{8'h00, 32'h0000_07F8, 32'h0000_0000,  80,  8,  8, S_PLAY};
    vecs[9]  = '{8'h00, 32'h0000_0FF8, 32'h0000_0000,  90,  9,  9, S_PLAY};
    vecs[10] = '{8'h00, 32'h0000_1FF8, 32'h0000_0000, 100, 10, 10, S_PLAY};
    vecs[11] = '{8'h00, 32'h0000_3FF8, 32'h0000_0000, 115, 11, 11, S_PLAY};
    vecs[12] = '{8'h00, 32'h0000_7FF8, 32'h0000_0000, 130, 12, 12, S_PLAY};
    vecs[13] = '{8'h00, 32'h0000_7FF8, 32'h0000_8000, 130,  0, 12, S_PLAY};
    vecs[14] = '{8'h01, 32'h0000_7FF8, 32'h0000_8000, 130,  0, 12, S_IDLE};
    vecs[15] = '{8'h00, 32'h0010_7FF8, 32'h0000_8000, 130,  0, 12, S_IDLE};
    vecs[16] = '{8'h2C, 32'h0030_7FF8, 32'h0000_8000,   0,  0,  0, S_PLAY};
    vecs[17] = '{8'h00, 32'h0030_7FF8, 32'h0000_8000,   0,  0,  0, S_PLAY};

    Reset   = 1'b1;
    keycode = 8'h00;
    hit     = '0;
    miss    = '0;
    #12;
    check_all("reset", 0, 0, 0, S_IDLE);
    step();
    Reset = 1'b0;
    step();
    check_all("post_reset", 0, 0, 0, S_IDLE);

    for (int i = 0; i < NV; i++) begin
      keycode = vecs[i].key;
      hit     = vecs[i].hit;
      miss    = vecs[i].miss;
      step();
      check_all($sformatf("row%0d", i), vecs[i].score, vecs[i].combo, vecs[i].maxc, vecs[i].st);
    end

    // Combo of 5, then a hit and a miss on different lanes in the same frame.
    do_reset();
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    for (int i = 0; i < 5; i++) begin
      hit[10 + i] = 1'b1;
      step();
      check($sformatf("build_score%0d", i), 32'(score), 32'(10 * (i + 1)));
    end
    hit[1]  = 1'b1;
    miss[2] = 1'b1;
    step();
    check_all("hit_and_miss", 60, 1, 5, S_PLAY);

    // Same-lane hit and miss together count as a hit; re-toggling is ignored.
    hit[0]  = 1'b1;
    miss[0] = 1'b1;
    step();
    check_all("same_lane", 70, 2, 5, S_PLAY);
    hit[0] = 1'b0;
    step();
    hit[0] = 1'b1;
    step();
    check_all("retoggle", 70, 2, 5, S_PLAY);

    // Remaining 24 lanes resolve in one frame: scored and DONE on that edge.
    hit = '1;
    step();
    check_all("all_resolved", 310, 26, 26, S_DONE);
    miss = '1;
    step();
    check_all("done_ignores", 310, 26, 26, S_DONE);
    keycode = 8'h01;
    step();
    check_all("done_to_idle", 310, 26, 26, S_IDLE);
    keycode = 8'h2C;
    step();
    check_all("restart", 0, 0, 0, S_PLAY);

    // Reach score 200, then reset asynchronously between edges.
    keycode = 8'h00;
    hit     = '0;
    miss    = '0;
    step();
    hit = 32'h000F_FFFF;
    step();
    check_all("score200", 200, 20, 20, S_PLAY);
    #2;
    Reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, S_IDLE);
    step();
    Reset = 1'b0;
    step();
    check_all("after_reset", 0, 0, 0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
